// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and default widths for the RAM burst initiator.
package ram_burst_pkg;

  localparam int unsigned ADD_WIDTH_DEF  = 8;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                     write;
    logic [ADD_WIDTH_DEF-1:0] add;
    logic [ADD_WIDTH_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Client command/stream handshakes plus the single-port RAM bus of ram_burst_ctrl.
interface ram_burst_ctrl_if
  import ram_burst_pkg::*;
#(
  parameter int unsigned add_width  = ADD_WIDTH_DEF,
  parameter int unsigned data_width = DATA_WIDTH_DEF
);

  logic                  Cmd_valid;
  logic                  Cmd_ready;
  logic                  Cmd_write;
  logic [add_width-1:0]  Cmd_add;
  logic [add_width-1:0]  Cmd_len;

  logic [data_width-1:0] Wr_data;
  logic                  Wr_valid;
  logic                  Wr_ready;

  logic [data_width-1:0] Rd_data;
  logic                  Rd_valid;
  logic                  Rd_ready;

  logic                  Done;

  logic                  Ram_write_enable;
  logic [add_width-1:0]  Ram_add;
  logic [data_width-1:0] Ram_data;
  logic [data_width-1:0] Ram_q;

  modport master (
    input  Cmd_valid, Cmd_write, Cmd_add, Cmd_len,
    input  Wr_data, Wr_valid, Rd_ready, Ram_q,
    output Cmd_ready, Wr_ready, Rd_data, Rd_valid, Done,
    output Ram_write_enable, Ram_add, Ram_data
  );

  modport slave (
    output Cmd_valid, Cmd_write, Cmd_add, Cmd_len,
    output Wr_data, Wr_valid, Rd_ready, Ram_q,
    input  Cmd_ready, Wr_ready, Rd_data, Rd_valid, Done,
    input  Ram_write_enable, Ram_add, Ram_data
  );

endinterface

// File: rtl/ram_burst_ctrl_rd_stage.sv
// One-entry registered read output stage: captures a word on load and holds it until accepted.
module ram_burst_rd_stage
  import ram_burst_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  load_i,
  input  logic [data_width-1:0] data_i,
  input  logic                  ready_i,
  output logic                  can_load_o,
  output logic [data_width-1:0] data_o,
  output logic                  valid_o
);

  logic [data_width-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Refill allowed in the same cycle the held word is consumed.
  assign can_load_o = !valid_q || ready_i;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port RAM with combinational read data.
// Optional XOR checksum output enabled by defining RAM_BURST_CHECKSUM_EN.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int unsigned add_width  = ADD_WIDTH_DEF,
  parameter int unsigned data_width = DATA_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  ram_burst_ctrl_if.master      bus
`ifdef RAM_BURST_CHECKSUM_EN
  ,
  output logic [data_width-1:0] Checksum
`endif
);

  state_e               state_q, state_d;
  logic [add_width-1:0] add_q, add_d;
  logic [add_width-1:0] count_q, count_d;
  logic                 fetched_q, fetched_d;

  cmd_t                  cmd;
  logic                  cmd_accept;
  logic                  wr_beat;
  logic                  rd_can_load;
  logic                  rd_load;
  logic                  rd_ready_eff;
  logic                  rd_take;
  logic [data_width-1:0] rd_data;
  logic                  rd_valid;

  assign cmd = '{write: bus.Cmd_write, add: bus.Cmd_add, len: bus.Cmd_len};

  assign cmd_accept   = (state_q == IDLE) && bus.Cmd_valid;
  assign wr_beat      = (state_q == WRITE) && bus.Wr_valid;
  assign rd_ready_eff = (state_q == READ) && bus.Rd_ready;
  assign rd_load      = (state_q == READ) && rd_can_load && !fetched_q;
  assign rd_take      = rd_valid && rd_ready_eff;

  always_comb begin
    state_d   = state_q;
    add_d     = add_q;
    count_d   = count_q;
    fetched_d = fetched_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          add_d     = cmd.add;
          count_d   = cmd.len;
          fetched_d = 1'b0;
          state_d   = cmd.write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_beat) begin
          add_d = add_q + add_width'(1);
          if (count_q == '0) state_d = DONE;
          else               count_d = count_q - add_width'(1);
        end
      end
      READ: begin
        // count tracks beats still to fetch; fetched marks the final load issued
        if (rd_load) begin
          add_d = add_q + add_width'(1);
          if (count_q == '0) fetched_d = 1'b1;
          else               count_d   = count_q - add_width'(1);
        end
        if (fetched_q && rd_take) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      add_q     <= '0;
      count_q   <= '0;
      fetched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      add_q     <= add_d;
      count_q   <= count_d;
      fetched_q <= fetched_d;
    end
  end

  ram_burst_rd_stage #(
    .data_width (data_width)
  ) u_rd_stage (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load_i     (rd_load),
    .data_i     (bus.Ram_q),
    .ready_i    (rd_ready_eff),
    .can_load_o (rd_can_load),
    .data_o     (rd_data),
    .valid_o    (rd_valid)
  );

  assign bus.Cmd_ready        = (state_q == IDLE);
  assign bus.Wr_ready         = (state_q == WRITE);
  assign bus.Done             = (state_q == DONE);
  assign bus.Ram_write_enable = wr_beat;
  assign bus.Ram_add          = add_q;
  assign bus.Ram_data         = bus.Wr_data;
  assign bus.Rd_data          = rd_data;
  assign bus.Rd_valid         = rd_valid;

`ifdef RAM_BURST_CHECKSUM_EN
  logic [data_width-1:0] csum_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)          csum_q <= '0;
    else if (cmd_accept) csum_q <= '0;
    else if (wr_beat)    csum_q <= csum_q ^ bus.Wr_data;
    else if (rd_take)    csum_q <= csum_q ^ rd_data;
  end

  assign Checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed plus randomized bench for ram_burst_ctrl against a behavioural memory model.
module tb_ram_burst_ctrl;

  logic Clk = 1'b0;
  logic Rst_n;
  logic tb_fill;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  ram_burst_ctrl_if #(.add_width(8), .data_width(32)) bus ();

`ifdef RAM_BURST_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  ram_burst_ctrl #(.add_width(8), .data_width(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
`ifdef RAM_BURST_CHECKSUM_EN
    ,
    .Checksum (checksum)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  // Memory instance attached to the RAM port.
  logic [31:0] mem [256];
  assign bus.Ram_q = mem[bus.Ram_add];
  always @(posedge Clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.Ram_write_enable) begin
      mem[bus.Ram_add] <= bus.Ram_data;
    end
  end

  // Expected memory contents, updated from the burst rules.
  logic [31:0] ref_mem [256];
  logic [31:0] wdata [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_wdata(input int n);
    wdata.delete();
    for (int i = 0; i < n; i++) wdata.push_back($urandom);
  endtask

  task automatic issue_cmd(input string tag, input logic wr, input logic [7:0] add, input logic [7:0] len);
    chk({tag, "_cmd_ready"}, 64'(bus.Cmd_ready), 64'd1);
    bus.Cmd_valid = 1'b1;
    bus.Cmd_write = wr;
    bus.Cmd_add   = add;
    bus.Cmd_len   = len;
    @(posedge Clk);
    #1;
    bus.Cmd_valid = 1'b0;
    bus.Cmd_add   = 8'($urandom);
    bus.Cmd_len   = 8'($urandom);
    chk({tag, "_start_add"}, 64'(bus.Ram_add), 64'(add));
    chk({tag, "_busy"}, 64'(bus.Cmd_ready), 64'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] add, input logic [7:0] len, input int mode);
    int          beats  = int'(len) + 1;
    int          idx    = 0;
    int          cyc    = 0;
    int          we_cnt = 0;
    logic [31:0] x      = '0;
    logic [7:0]  a;
    bit          v;
    issue_cmd(tag, 1'b1, add, len);
    chk({tag, "_wr_ready"}, 64'(bus.Wr_ready), 64'd1);
    while (idx < beats && cyc < 4 * beats + 50) begin
      v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a = add + 8'(idx);
      bus.Wr_valid = v;
      bus.Wr_data  = v ? wdata[idx] : $urandom;
      #1;
      chk({tag, "_we"}, 64'(bus.Ram_write_enable), 64'(v));
      if (v) begin
        chk({tag, "_beat_add"}, 64'(bus.Ram_add), 64'(a));
        we_cnt++;
      end
      @(posedge Clk);
      if (v) begin
        ref_mem[a] = wdata[idx];
        x ^= wdata[idx];
        idx++;
      end
      #1;
      cyc++;
    end
    bus.Wr_valid = 1'b0;
    chk({tag, "_beats_taken"}, 64'(idx), 64'(beats));
    chk({tag, "_we_cycles"}, 64'(we_cnt), 64'(beats));
    chk({tag, "_done"}, 64'(bus.Done), 64'd1);
    chk({tag, "_done_no_cmd"}, 64'(bus.Cmd_ready), 64'd0);
    chk({tag, "_we_after"}, 64'(bus.Ram_write_enable), 64'd0);
`ifdef RAM_BURST_CHECKSUM_EN
    chk({tag, "_checksum"}, 64'(checksum), 64'(x));
`endif
    @(posedge Clk);
    #1;
    chk({tag, "_done_once"}, 64'(bus.Done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.Cmd_ready), 64'd1);
  endtask

  // mode 0: Rd_ready high, 1: pattern 1,0,0,1, 2: random
  task automatic do_read(input string tag, input logic [7:0] add, input logic [7:0] len, input int mode);
    int          beats = int'(len) + 1;
    int          idx   = 0;
    int          cyc   = 0;
    logic [31:0] x     = '0;
    logic [31:0] prev_data = '0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          rdy;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    issue_cmd(tag, 1'b0, add, len);
    while (idx < beats && cyc < 4 * beats + 50) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.Rd_ready = rdy;
      #1;
      if (cyc == 0) chk({tag, "_no_valid_first"}, 64'(bus.Rd_valid), 64'd0);
      if (cyc == 1) chk({tag, "_valid_latency"}, 64'(bus.Rd_valid), 64'd1);
      if (prev_valid && !prev_ready) begin
        chk({tag, "_stall_valid"}, 64'(bus.Rd_valid), 64'd1);
        chk({tag, "_stall_data"}, 64'(bus.Rd_data), 64'(prev_data));
      end
      chk({tag, "_no_early_done"}, 64'(bus.Done), 64'd0);
      if (bus.Rd_valid && rdy) begin
        chk({tag, "_data"}, 64'(bus.Rd_data), 64'(ref_mem[add + 8'(idx)]));
        x ^= bus.Rd_data;
        idx++;
      end
      prev_valid = bus.Rd_valid;
      prev_ready = rdy;
      prev_data  = bus.Rd_data;
      @(posedge Clk);
      #1;
      cyc++;
    end
    bus.Rd_ready = 1'b0;
    chk({tag, "_beats_taken"}, 64'(idx), 64'(beats));
    if (mode == 0) chk({tag, "_throughput"}, 64'(cyc), 64'(beats + 1));
    chk({tag, "_done"}, 64'(bus.Done), 64'd1);
    chk({tag, "_valid_clear"}, 64'(bus.Rd_valid), 64'd0);
`ifdef RAM_BURST_CHECKSUM_EN
    chk({tag, "_checksum"}, 64'(checksum), 64'(x));
`endif
    @(posedge Clk);
    #1;
    chk({tag, "_done_once"}, 64'(bus.Done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.Cmd_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rl;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    Rst_n         = 1'b0;
    tb_fill       = 1'b1;
    bus.Cmd_valid = 1'b0;
    bus.Cmd_write = 1'b0;
    bus.Cmd_add   = '0;
    bus.Cmd_len   = '0;
    bus.Wr_valid  = 1'b0;
    bus.Wr_data   = '0;
    bus.Rd_ready  = 1'b0;
    @(posedge Clk);
    #1;
    tb_fill = 1'b0;
    chk("rst_cmd_ready", 64'(bus.Cmd_ready), 64'd1);
    chk("rst_wr_ready", 64'(bus.Wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(bus.Rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.Rd_data), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_we", 64'(bus.Ram_write_enable), 64'd0);
    chk("rst_ram_add", 64'(bus.Ram_add), 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed write/read of four beats at 0x10.
    wdata.delete();
    for (int i = 1; i <= 4; i++) wdata.push_back(32'(i));
    do_write("wr4", 8'h10, 8'd3, 0);
    do_read("rd4", 8'h10, 8'd3, 0);
    do_read("rd4_stall", 8'h10, 8'd3, 1);

    // Wrap across the top address.
    fill_wdata(3);
    do_write("wrap", 8'hFE, 8'd2, 0);
    chk("wrap_mem_fe", 64'(mem[8'hFE]), 64'(wdata[0]));
    chk("wrap_mem_ff", 64'(mem[8'hFF]), 64'(wdata[1]));
    chk("wrap_mem_00", 64'(mem[8'h00]), 64'(wdata[2]));
    do_read("wrap_rd", 8'hFE, 8'd2, 2);

    // Checksum pattern.
    wdata.delete();
    wdata.push_back(32'hA5A5_A5A5);
    wdata.push_back(32'h0F0F_0F0F);
    do_write("csum_wr", 8'h20, 8'd1, 0);
`ifdef RAM_BURST_CHECKSUM_EN
    chk("csum_value", 64'(wdata[0] ^ wdata[1]), 64'(32'hAAAA_AAAA));
`endif

    // Reset during the second beat of a four-beat write.
    fill_wdata(4);
    issue_cmd("rst_mid", 1'b1, 8'h40, 8'd3);
    bus.Wr_valid = 1'b1;
    bus.Wr_data  = wdata[0];
    @(posedge Clk);
    ref_mem[8'h40] = wdata[0];
    #1;
    bus.Wr_data = wdata[1];
    #1;
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(bus.Ram_write_enable), 64'd0);
    chk("rst_mid_wr_ready", 64'(bus.Wr_ready), 64'd0);
    chk("rst_mid_ram_add", 64'(bus.Ram_add), 64'd0);
    chk("rst_mid_rd_data", 64'(bus.Rd_data), 64'd0);
    chk("rst_mid_done", 64'(bus.Done), 64'd0);
    chk("rst_mid_cmd_ready", 64'(bus.Cmd_ready), 64'd1);
    bus.Wr_valid = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_mid_no_done", 64'(bus.Done), 64'd0);
    do_read("rst_mid_rd", 8'h40, 8'd3, 0);

    // Randomized bursts.
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom);
      rl = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_wdata(int'(rl) + 1);
        do_write("rnd_wr", ra, rl, int'($urandom_range(0, 1)) * 2);
      end else begin
        do_read("rnd_rd", ra, rl, int'($urandom_range(0, 2)));
      end
    end

    // Full-size burst touches every location once.
    ra = 8'($urandom);
    fill_wdata(256);
    do_write("full_wr", ra, 8'hFF, 2);
    do_read("full_rd", ra + 8'd7, 8'hFF, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator side of the team's single-port RAM interface (write enable, address, write data, combinational read data). Accepts a burst command (start address, beat count, direction) and sequences the RAM port. Streams write data in, or read data out, over valid/ready handshakes. Sits between a DMA-style client and a ram128x32-class memory instance.

Parameters:
add_width, 8, RAM address width; also the burst-length field width
data_width, 32, RAM data width

Ports:
Clk  input  1  clock, all logic on posedge
Rst_n  input  1  asynchronous active-low reset
Cmd_valid  input  1  command offered
Cmd_ready  output  1  high only in IDLE
Cmd_write  input  1  1 = write burst, 0 = read burst
Cmd_add  input  add_width  burst start address
Cmd_len  input  add_width  beats minus one (0 = 1 beat, all-ones = 2**add_width beats)
Wr_data  input  data_width  write beat data
Wr_valid  input  1  write beat offered
Wr_ready  output  1  high only in WRITE
Rd_data  output  data_width  read beat data (registered)
Rd_valid  output  1  read beat offered
Rd_ready  input  1  read beat accepted
Done  output  1  one-cycle pulse after the final beat of a burst
Ram_write_enable  output  1  to RAM Write_enable
Ram_add  output  add_width  to RAM Add
Ram_data  output  data_width  to RAM Data
Ram_q  input  data_width  from RAM Q, combinational read of Ram_add

Behaviour:
- Reset (Rst_n low, async): state IDLE; Rd_valid, Done, Ram_write_enable = 0; Rd_data, Ram_add and the beat counter = 0.
- The reset takes effect mid-burst, abandons the burst with no Done, and returns to IDLE. RAM contents already written stay untouched.
- States: IDLE, WRITE, READ, DONE.
- IDLE: Cmd_ready = 1. On Cmd_valid, latch Ram_add <= Cmd_add and count <= Cmd_len. Go to WRITE if Cmd_write, else READ.
- WRITE:
  - Wr_ready = 1; Ram_write_enable = Wr_valid (combinational); Ram_data = Wr_data.
  - Each accepted beat (Wr_valid && Wr_ready) writes at the current Ram_add. The address then increments.
  - On the beat where count == 0, go to DONE; otherwise count decrements.
  - A Wr_valid gap stalls the burst with no write.
- READ:
  - A load happens when (!Rd_valid || Rd_ready) and beats remain to fetch. The load sets Rd_data <= Ram_q, sets Rd_valid, and increments Ram_add.
  - Latency: 1 cycle from address to Rd_valid.
  - Full throughput: with Rd_ready held high, one beat per cycle.
  - Rd_data must hold stable while Rd_valid && !Rd_ready.
  - A fetched flag tracks the last load. After the last beat is accepted with no new load, Rd_valid clears and the state goes to DONE.
- DONE: Done = 1 for exactly one cycle, then IDLE. Cmd_ready = 0 in DONE, so back-to-back commands are spaced by at least one cycle.
- Address arithmetic is modulo 2**add_width. A burst crossing the top address wraps to 0.
- Cmd_len all-ones touches every location exactly once.
- Ram_write_enable is never asserted outside WRITE. Ram_data is don't-care outside WRITE.
- Wr_valid outside WRITE is ignored. Rd_ready outside READ is ignored.

Optional Feature:
- Macro: RAM_BURST_CHECKSUM_EN.
- With the macro: an extra output Checksum [data_width-1:0] is added.
  - Cleared to 0 on command accept and on reset.
  - XOR-accumulates every transferred beat: each write beat accepted, and each read beat when it is accepted by Rd_ready.
  - Final value is valid in the Done cycle and held until the next command accept.
- Without the macro: no port and no logic.

Decomposition:
- Package ram_burst_pkg holds:
  - the state enum (IDLE, WRITE, READ, DONE);
  - default width localparams;
  - a command struct {write, add, len}.
- Natural sub-module: ram_burst_rd_stage, the one-entry registered read output stage (Rd_data/Rd_valid hold logic). It is reusable for other RAM readers.
- The FSM and counters stay in the top module.

Test Plan:
- Write burst, Cmd_add=8'h10, Cmd_len=3, Wr_valid continuous with data 1,2,3,4 -> RAM[10..13]=1..4; Ram_write_enable high 4 cycles; Done pulses 1 cycle after the 4th beat.
- Read burst of the same 4 locations with Rd_ready high -> Rd_data 1,2,3,4 on consecutive cycles; first Rd_valid 1 cycle after READ entry; Done once.
- Read burst with Rd_ready toggling 1,0,0,1 -> no lost or duplicated beats; Rd_data stable while stalled.
- Wrap: write Cmd_add=8'hFE, Cmd_len=2 -> writes land at FE, FF, 00.
- Reset asserted on the 2nd beat of a 4-beat write -> outputs 0 immediately; only beat 1 written; no Done; next command accepted normally.
- With RAM_BURST_CHECKSUM_EN: write beats A5A5A5A5 and 0F0F0F0F -> Checksum = AAAAAAAA in the Done cycle.
